// File: rtl/pll_phase_ctrl.sv
// PLL phase-step controller: sequences the PLL reset pulse, waits for a
// stable lock, then walks a selected PLL output through phase steps using
// the phasestep/phaseloadreg handshake while tracking each output's phase.
module pll_phase_ctrl #(
  parameter int NUM_CH         = 4,
  parameter int LOCK_CYCLES    = 16,
  parameter int RELOCK_TIMEOUT = 1000,
  parameter int RST_CYCLES     = 8,
  parameter int PULSE_CYCLES   = 2,
  parameter int STEP_W         = 4,
  parameter int PHASE_W        = 3,
  parameter int PHASE_MOD      = 8
) (
  input  logic                        clock_in,
  input  logic                        reset_n,
  input  logic                        locked,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [1:0]                  req_chan,
  input  logic                        req_dir,
  input  logic [STEP_W-1:0]           req_steps,
  output logic                        pll_rst,
  output logic [1:0]                  phasesel,
  output logic                        phasedir,
  output logic                        phasestep,
  output logic                        phaseloadreg,
  output logic                        lock_ok,
  output logic                        busy,
  output logic                        done,
  output logic                        abort,
  output logic [7:0]                  relock_count,
  output logic [NUM_CH*PHASE_W-1:0]   phase_pos
);

  localparam int CNT_W  = $clog2(RELOCK_TIMEOUT + RST_CYCLES + PULSE_CYCLES + 1);
  localparam int LCNT_W = $clog2(LOCK_CYCLES + 1);
  localparam int POS_W  = NUM_CH * PHASE_W;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    LOCKED    = 3'd2,
    SETUP     = 3'd3,
    STEP_LO   = 3'd4,
    STEP_HI   = 3'd5,
    LOAD      = 3'd6
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [LCNT_W-1:0]   lcnt, lcnt_nxt;
  logic [1:0]          ch_r, ch_nxt;
  logic                dir_r, dir_nxt;
  logic [STEP_W-1:0]   left_r, left_nxt;
  logic                sync_meta, sync_lock;
  logic                chan_bad;
  logic                ready_nxt, pll_rst_nxt, phasedir_nxt, step_nxt, load_nxt;
  logic                lock_ok_nxt, busy_nxt, done_nxt, abort_nxt;
  logic [1:0]          phasesel_nxt;
  logic [7:0]          relock_nxt;
  logic [POS_W-1:0]    pos_nxt;

  // One phase position moved one step with wrap at PHASE_MOD.
  function automatic logic [PHASE_W-1:0] step_pos(input logic [PHASE_W-1:0] p, input logic up);
    logic [PHASE_W-1:0] r;
    if (up) r = (p == PHASE_W'(PHASE_MOD - 1)) ? '0 : p + PHASE_W'(1);
    else    r = (p == '0) ? PHASE_W'(PHASE_MOD - 1) : p - PHASE_W'(1);
    return r;
  endfunction

  // Whole position vector with only the addressed channel stepped.
  function automatic logic [POS_W-1:0] bump_pos(input logic [POS_W-1:0] pv, input logic [1:0] ch,
                                                input logic up);
    logic [POS_W-1:0] r;
    for (int i = 0; i < NUM_CH; i++)
      r[i*PHASE_W +: PHASE_W] = (ch == 2'(i)) ? step_pos(pv[i*PHASE_W +: PHASE_W], up)
                                              : pv[i*PHASE_W +: PHASE_W];
    return r;
  endfunction

  assign chan_bad = ({30'd0, req_chan} >= 32'(NUM_CH));

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      sync_lock <= 1'b0;
    end else begin
      sync_meta <= locked;
      sync_lock <= sync_meta;
    end
  end

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    lcnt_nxt     = lcnt;
    ch_nxt       = ch_r;
    dir_nxt      = dir_r;
    left_nxt     = left_r;
    pll_rst_nxt  = 1'b0;
    phasesel_nxt = phasesel;
    phasedir_nxt = phasedir;
    step_nxt     = 1'b1;
    load_nxt     = 1'b1;
    lock_ok_nxt  = 1'b0;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    abort_nxt    = 1'b0;
    relock_nxt   = relock_count;
    pos_nxt      = phase_pos;
    case (state)
      RESET_PLL: begin
        pos_nxt = '0;
        if (cnt == CNT_W'(RST_CYCLES - 1)) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
          lcnt_nxt  = '0;
        end else begin
          pll_rst_nxt = 1'b1;
          cnt_nxt     = cnt + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        if (sync_lock && (lcnt == LCNT_W'(LOCK_CYCLES - 1))) begin
          state_nxt   = LOCKED;
          lock_ok_nxt = 1'b1;
        end else if (cnt == CNT_W'(RELOCK_TIMEOUT - 1)) begin
          state_nxt   = RESET_PLL;
          cnt_nxt     = '0;
          pll_rst_nxt = 1'b1;
          pos_nxt     = '0;
          relock_nxt  = (relock_count == 8'hFF) ? relock_count : relock_count + 8'd1;
        end else begin
          cnt_nxt  = cnt + CNT_W'(1);
          lcnt_nxt = sync_lock ? lcnt + LCNT_W'(1) : '0;
        end
      end
      LOCKED: begin
        if (!sync_lock) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
          lcnt_nxt  = '0;
        end else begin
          lock_ok_nxt = 1'b1;
          if (req_valid && req_ready) begin
            ch_nxt       = req_chan;
            dir_nxt      = req_dir;
            left_nxt     = req_steps;
            phasesel_nxt = req_chan;
            phasedir_nxt = req_dir;
            if (chan_bad) begin
              abort_nxt = 1'b1;
            end else begin
              state_nxt = SETUP;
              busy_nxt  = 1'b1;
            end
          end else begin
            state_nxt = LOCKED;
          end
        end
      end
      SETUP, STEP_LO, STEP_HI, LOAD: begin
        if (!sync_lock) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
          lcnt_nxt  = '0;
          abort_nxt = 1'b1;
        end else begin
          lock_ok_nxt = 1'b1;
          busy_nxt    = 1'b1;
          if (state == SETUP) begin
            cnt_nxt = '0;
            if (left_r == '0) begin
              state_nxt = LOAD;
              load_nxt  = 1'b0;
            end else begin
              state_nxt = STEP_LO;
              step_nxt  = 1'b0;
            end
          end else if (state == STEP_LO) begin
            if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
              state_nxt = STEP_HI;
              cnt_nxt   = '0;
              pos_nxt   = bump_pos(phase_pos, ch_r, dir_r);
              left_nxt  = left_r - STEP_W'(1);
            end else begin
              cnt_nxt  = cnt + CNT_W'(1);
              step_nxt = 1'b0;
            end
          end else if (state == STEP_HI) begin
            if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
              cnt_nxt = '0;
              if (left_r == '0) begin
                state_nxt = LOAD;
                load_nxt  = 1'b0;
              end else begin
                state_nxt = STEP_LO;
                step_nxt  = 1'b0;
              end
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end else begin
            state_nxt = LOCKED;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt   = RESET_PLL;
        cnt_nxt     = '0;
        pll_rst_nxt = 1'b1;
      end
    endcase
    // Ready mirrors the next state together with the next synchronised lock.
    ready_nxt = (state_nxt == LOCKED) && sync_meta;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RESET_PLL;
      cnt          <= '0;
      lcnt         <= '0;
      ch_r         <= 2'd0;
      dir_r        <= 1'b1;
      left_r       <= '0;
      req_ready    <= 1'b0;
      pll_rst      <= 1'b1;
      phasesel     <= 2'd0;
      phasedir     <= 1'b1;
      phasestep    <= 1'b1;
      phaseloadreg <= 1'b1;
      lock_ok      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      abort        <= 1'b0;
      relock_count <= 8'd0;
      phase_pos    <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      lcnt         <= lcnt_nxt;
      ch_r         <= ch_nxt;
      dir_r        <= dir_nxt;
      left_r       <= left_nxt;
      req_ready    <= ready_nxt;
      pll_rst      <= pll_rst_nxt;
      phasesel     <= phasesel_nxt;
      phasedir     <= phasedir_nxt;
      phasestep    <= step_nxt;
      phaseloadreg <= load_nxt;
      lock_ok      <= lock_ok_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      abort        <= abort_nxt;
      relock_count <= relock_nxt;
      phase_pos    <= pos_nxt;
    end
  end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Bench for pll_phase_ctrl: instance a uses default parameters, instance b
// uses 3 channels and short timers for relock saturation and bad-channel abort.
module tb_pll_phase_ctrl;

  logic clk = 1'b0;
  logic rst_n, rst_nb, locked_a, locked_b, req_valid, sel, req_dir;
  logic [1:0] req_chan;
  logic [3:0] req_steps;

  logic a_ready, a_pll_rst, a_dir, a_step, a_load, a_lock_ok, a_busy, a_done, a_abort;
  logic [1:0] a_sel;
  logic [7:0] a_relock;
  logic [11:0] a_pos;
  logic b_ready, b_pll_rst, b_dir, b_step, b_load, b_lock_ok, b_busy, b_done, b_abort;
  logic [1:0] b_sel;
  logic [7:0] b_relock;
  logic [8:0] b_pos;

  logic s_ready, s_dir, s_step, s_load, s_lock_ok, s_busy, s_done, s_abort;
  logic [1:0] s_sel;
  logic [11:0] s_pos;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pll_phase_ctrl dut_a (
    .clock_in(clk), .reset_n(rst_n), .locked(locked_a),
    .req_valid(req_valid & ~sel), .req_ready(a_ready), .req_chan(req_chan),
    .req_dir(req_dir), .req_steps(req_steps), .pll_rst(a_pll_rst), .phasesel(a_sel),
    .phasedir(a_dir), .phasestep(a_step), .phaseloadreg(a_load), .lock_ok(a_lock_ok),
    .busy(a_busy), .done(a_done), .abort(a_abort), .relock_count(a_relock), .phase_pos(a_pos)
  );

  pll_phase_ctrl #(.NUM_CH(3), .LOCK_CYCLES(4), .RELOCK_TIMEOUT(20), .RST_CYCLES(4)) dut_b (
    .clock_in(clk), .reset_n(rst_nb), .locked(locked_b),
    .req_valid(req_valid & sel), .req_ready(b_ready), .req_chan(req_chan),
    .req_dir(req_dir), .req_steps(req_steps), .pll_rst(b_pll_rst), .phasesel(b_sel),
    .phasedir(b_dir), .phasestep(b_step), .phaseloadreg(b_load), .lock_ok(b_lock_ok),
    .busy(b_busy), .done(b_done), .abort(b_abort), .relock_count(b_relock), .phase_pos(b_pos)
  );

  assign s_ready   = sel ? b_ready   : a_ready;
  assign s_dir     = sel ? b_dir     : a_dir;
  assign s_step    = sel ? b_step    : a_step;
  assign s_load    = sel ? b_load    : a_load;
  assign s_lock_ok = sel ? b_lock_ok : a_lock_ok;
  assign s_busy    = sel ? b_busy    : a_busy;
  assign s_done    = sel ? b_done    : a_done;
  assign s_abort   = sel ? b_abort   : a_abort;
  assign s_sel     = sel ? b_sel     : a_sel;
  assign s_pos     = sel ? {3'd0, b_pos} : a_pos;

  typedef struct {
    logic [1:0] ch;
    logic       dir;
    logic [3:0] steps;
    logic       exp_abort;
    logic [2:0] exp_pos;
  } vec_t;

  typedef struct {
    logic       exp_abort;
    int         lat;
    int         lows;
    logic [1:0] ch;
    logic [2:0] pos;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int chpos(input logic [11:0] pv, input logic [1:0] ch);
    logic [11:0] t;
    t = pv >> (3 * ch);
    return int'(t[2:0]);
  endfunction

  // Issue one request on the selected instance and score its completion.
  task automatic run_req(input vec_t v, input int drop_at, input int lat, input int lows);
    exp_t e;
    int k, nlow, nload, g;
    g = 0;
    while (s_ready !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    chk("ready_before_req", int'(s_ready), 1);
    req_chan = v.ch; req_dir = v.dir; req_steps = v.steps; req_valid = 1'b1;
    e.exp_abort = v.exp_abort; e.lat = lat; e.lows = lows; e.ch = v.ch; e.pos = v.exp_pos;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    chk("phasesel", int'(s_sel), int'(v.ch));
    chk("phasedir", int'(s_dir), int'(v.dir));
    if (!v.exp_abort) begin
      chk("busy_setup", int'(s_busy), 1);
      chk("ready_while_busy", int'(s_ready), 0);
    end
    k = 0; nlow = 0; nload = 0;
    while (!(s_done === 1'b1 || s_abort === 1'b1) && k < 200) begin
      if (s_step === 1'b0) nlow++;
      if (s_load === 1'b0) nload++;
      if (k == drop_at) locked_a = 1'b0;
      @(negedge clk);
      k++;
    end
    e = sb.pop_front();
    chk("latency", k, e.lat);
    chk("abort_flag", int'(s_abort), int'(e.exp_abort));
    chk("done_flag", int'(s_done), int'(!e.exp_abort));
    chk("step_low_cycles", nlow, e.lows);
    chk("load_low_cycles", nload, e.exp_abort ? 0 : 1);
    chk("phase_pos_ch", chpos(s_pos, e.ch), int'(e.pos));
    chk("idle_phasestep", int'(s_step), 1);
    @(negedge clk);
    chk("pulse_one_cycle", int'(s_done | s_abort), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, rises, cyc;
    logic prev;
    vecs[0] = '{2'd2, 1'b1, 4'd3,  1'b0, 3'd3};
    vecs[1] = '{2'd1, 1'b0, 4'd1,  1'b0, 3'd7};
    vecs[2] = '{2'd1, 1'b1, 4'd9,  1'b0, 3'd0};
    vecs[3] = '{2'd0, 1'b1, 4'd0,  1'b0, 3'd0};
    vecs[4] = '{2'd3, 1'b0, 4'd2,  1'b0, 3'd6};
    vecs[5] = '{2'd0, 1'b1, 4'd15, 1'b0, 3'd7};
    vecs[6] = '{2'd3, 1'b1, 4'd3,  1'b0, 3'd1};
    vecs[7] = '{2'd2, 1'b0, 4'd4,  1'b0, 3'd7};

    rst_n = 1'b1; rst_nb = 1'b0; locked_a = 1'b1; locked_b = 1'b0;
    req_valid = 1'b0; sel = 1'b0; req_chan = 2'd0; req_dir = 1'b0; req_steps = 4'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pll_rst", int'(a_pll_rst), 1);
    chk("rst_phasestep", int'(a_step), 1);
    chk("rst_phaseloadreg", int'(a_load), 1);
    chk("rst_phasesel", int'(a_sel), 0);
    chk("rst_phasedir", int'(a_dir), 1);
    chk("rst_lock_ok", int'(a_lock_ok), 0);
    chk("rst_ready", int'(a_ready), 0);
    chk("rst_busy_done_abort", int'({a_busy, a_done, a_abort}), 0);
    chk("rst_relock", int'(a_relock), 0);
    chk("rst_pos", int'(a_pos), 0);

    // Power-up lock: 8 reset cycles, then 16 synced-lock cycles.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (a_pll_rst === 1'b1 && k < 50) begin @(negedge clk); k++; end
    chk("pll_rst_len", k, 8);
    while (a_lock_ok !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    chk("lock_time", k, 24);
    chk("lock_relock", int'(a_relock), 0);
    chk("lock_ready", int'(a_ready), 1);

    // Table of phase-step requests.
    for (int i = 0; i < 8; i++)
      run_req(vecs[i], -1, 4 * int'(vecs[i].steps) + 2, 2 * int'(vecs[i].steps));
    chk("pos_after_table", int'(a_pos), int'(12'b001_111_000_111));

    // Lock lost during the third low half of a 5-step request.
    run_req('{2'd0, 1'b1, 4'd5, 1'b1, 3'd1}, 8, 11, 6);
    chk("drop_lock_ok", int'(a_lock_ok), 0);
    chk("drop_busy", int'(a_busy), 0);
    chk("drop_ready", int'(a_ready), 0);

    // Relock keeps positions; lock loss in LOCKED drops lock_ok after sync delay.
    locked_a = 1'b1;
    k = 0;
    while (a_lock_ok !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    chk("relock_time", k, 18);
    chk("pos_kept", int'(a_pos), int'(12'b001_111_000_001));
    locked_a = 1'b0;
    k = 0;
    while (a_lock_ok === 1'b1 && k < 20) begin @(negedge clk); k++; end
    chk("lock_loss_delay", k, 3);

    // Timeouts: repulse every 1000+8 cycles with counting relocks.
    for (int r = 1; r <= 3; r++) begin
      k = 0;
      while (a_pll_rst !== 1'b1 && k < 1100) begin @(negedge clk); k++; end
      chk("timeout_cycles", k, 1000);
      chk("relock_count", int'(a_relock), r);
      chk("pos_cleared", int'(a_pos), 0);
      k = 0;
      while (a_pll_rst === 1'b1 && k < 20) begin @(negedge clk); k++; end
      chk("repulse_len", k, 8);
    end

    // Asynchronous reset in the middle of a step pulse.
    locked_a = 1'b1;
    run_req('{2'd1, 1'b1, 4'd2, 1'b0, 3'd2}, -1, 10, 4);
    req_chan = 2'd0; req_dir = 1'b1; req_steps = 4'd5; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_step_low", int'(a_step), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_phasestep", int'(a_step), 1);
    chk("async_pll_rst", int'(a_pll_rst), 1);
    chk("async_pos", int'(a_pos), 0);
    chk("async_relock", int'(a_relock), 0);
    chk("async_lock_ok_busy", int'({a_lock_ok, a_busy}), 0);

    // Instance b: relock counter saturation over 300 timeouts.
    @(negedge clk);
    sel = 1'b1;
    rst_nb = 1'b1;
    rises = 0; cyc = 0; prev = b_pll_rst;
    while (rises < 300 && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (b_pll_rst === 1'b1 && prev === 1'b0) begin
        rises++;
        if (rises <= 2 || (rises >= 254 && rises <= 256) || rises == 300)
          chk("relock_sat", int'(b_relock), (rises > 255) ? 255 : rises);
      end
      prev = b_pll_rst;
    end
    chk("timeouts_seen", rises, 300);
    chk("sat_period_cycles", cyc, 300 * 24);

    // Instance b: out-of-range channel aborts, valid channel still steps.
    locked_b = 1'b1;
    k = 0;
    while (b_lock_ok !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    chk("b_locked", int'(b_lock_ok), 1);
    run_req('{2'd3, 1'b0, 4'd2, 1'b1, 3'd0}, -1, 0, 0);
    chk("b_pos_untouched", int'(s_pos), 0);
    chk("b_lock_after_abort", int'(b_lock_ok), 1);
    run_req('{2'd2, 1'b0, 4'd1, 1'b0, 3'd7}, -1, 6, 2);
    chk("b_pos_final", int'(s_pos), int'(12'h1C0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_phase_ctrl.md
PLL_PHASE_CTRL -- requirements
Module: pll_phase_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of phase-steppable PLL outputs (1..4, maps to PHASESEL 0..NUM_CH-1).
REQ-002 SHALL have parameter LOCK_CYCLES, default 16, consecutive synced-lock cycles required to declare lock.
REQ-003 SHALL have parameter RELOCK_TIMEOUT, default 1000, cycles allowed in WAIT_LOCK before forcing a PLL reset.
REQ-004 SHALL have parameter RST_CYCLES, default 8, length of the pll_rst pulse.
REQ-005 SHALL have parameter PULSE_CYCLES, default 2, length of each phasestep low and high half.
REQ-006 SHALL have parameter STEP_W, default 4, width of req_steps; PHASE_W, default 3, width of each phase position; PHASE_MOD, default 8, phase wrap modulus (<= 2^PHASE_W).
REQ-007 SHALL have ports: clock_in in 1 reference clock; reset_n in 1 asynchronous active-low reset; locked in 1 raw PLL LOCK (asynchronous).
REQ-008 SHALL have ports: req_valid in 1; req_ready out 1; req_chan in 2; req_dir in 1 (1 = increment); req_steps in STEP_W.
REQ-009 SHALL have ports: pll_rst out 1; phasesel out 2; phasedir out 1; phasestep out 1 (idle high); phaseloadreg out 1 (idle high).
REQ-010 SHALL have ports: lock_ok out 1; busy out 1; done out 1 (pulse); abort out 1 (pulse); relock_count out 8; phase_pos out NUM_CH*PHASE_W (channel i at bits [i*PHASE_W +: PHASE_W]).

Function
REQ-011 SHALL synchronise locked through two flops; all lock decisions use the synchronised value.
REQ-012 SHALL implement states RESET_PLL, WAIT_LOCK, LOCKED, SETUP, STEP_LO, STEP_HI, LOAD.
REQ-013 RESET_PLL: pll_rst=1 for exactly RST_CYCLES cycles, clear all phase_pos to 0, then enter WAIT_LOCK.
REQ-014 WAIT_LOCK: count consecutive synced-lock-high cycles; a low cycle clears the count; count reaching LOCK_CYCLES -> LOCKED with lock_ok=1 the same edge.
REQ-015 WAIT_LOCK: if RELOCK_TIMEOUT cycles elapse without lock -> RESET_PLL and relock_count increments, saturating at 255.
REQ-016 req_ready SHALL be 1 only in LOCKED with synced lock high; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-017 On acceptance: latch req_chan/req_dir/req_steps, drive phasesel=req_chan and phasedir=req_dir, enter SETUP (1 cycle), busy=1 from SETUP until return to LOCKED.
REQ-018 Each step: phasestep=0 for PULSE_CYCLES (STEP_LO), then 1 for PULSE_CYCLES (STEP_HI); the addressed phase_pos updates on the STEP_LO->STEP_HI edge.
REQ-019 phase_pos update: dir=1 -> (pos+1) mod PHASE_MOD, PHASE_MOD-1 wraps to 0; dir=0 -> (pos-1) mod PHASE_MOD, 0 wraps to PHASE_MOD-1.
REQ-020 After the last step: LOAD drives phaseloadreg=0 for 1 cycle, then LOCKED with done=1 for 1 cycle; done occurs 2*PULSE_CYCLES*N+2 cycles after the accepting edge.
REQ-021 req_steps=0: SETUP then LOAD, no phasestep pulse, phase_pos unchanged, done 2 cycles after acceptance.
REQ-022 req_chan >= NUM_CH: accepted, no pulses, phase_pos unchanged, abort=1 for 1 cycle the next cycle, return to LOCKED.
REQ-023 Synced lock low in LOCKED: lock_ok=0 same edge, enter WAIT_LOCK with timeout counter cleared.
REQ-024 Synced lock low during SETUP/STEP_LO/STEP_HI/LOAD: phasestep and phaseloadreg return high next edge, abort=1 for 1 cycle, enter WAIT_LOCK; phase_pos keeps only completed steps.
REQ-025 lock_ok SHALL be 1 only in LOCKED, SETUP, STEP_LO, STEP_HI, LOAD.

Reset
REQ-026 reset_n low SHALL asynchronously force: state RESET_PLL with cycle counter 0, pll_rst=1, phasestep=1, phaseloadreg=1, phasesel=0, phasedir=1, lock_ok=0, req_ready=0, busy=0, done=0, abort=0, relock_count=0, phase_pos all 0, sync flops 0.
REQ-027 Reset release SHALL begin the RST_CYCLES count on the first clock edge after reset_n rises.

Verification
REQ-028 Defaults, locked held 1 from release -> pll_rst high 8 cycles, lock_ok=1 16 cycles after synced lock, relock_count=0.
REQ-029 Locked held 0 -> pll_rst repulses every 1000+8 cycles, relock_count 1,2,3...; force 300 timeouts -> saturates at 255.
REQ-030 Request chan=2 dir=1 steps=3 -> three 2-cycle phasestep lows, phaseloadreg low 1 cycle, done 14 cycles after accept, phase_pos[2]=3.
REQ-031 From pos 0: chan=1 dir=0 steps=1 -> phase_pos[1]=7; then dir=1 steps=9 -> phase_pos[1]=0.
REQ-032 steps=5 on chan 0, drop locked during 3rd STEP_LO -> abort pulse, phasestep high, lock_ok=0, phase_pos[0]=2.
REQ-033 reset_n low mid-STEP_LO -> phasestep=1, pll_rst=1, phase_pos=0 immediately without a clock edge.
